// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter: shares one synchronous palette-ROM read port between a
// strict-priority background requester (index 0) and round-robin sprite
// requesters. Saturating per-sprite starve counters let a long-denied sprite
// preempt the background path. A tag pipeline that matches the ROM latency
// returns each ROM word to the requester that issued the read.
module rom_port_arbiter #(
   parameter int N_REQ      = 3,
   parameter int ADDR_W     = 18,
   parameter int DATA_W     = 5,
   parameter int ROM_LAT    = 1,
   parameter int STARVE_MAX = 8
) (
   input  logic                    vga_clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*ADDR_W-1:0] req_addr,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rd_valid,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    bg_miss,
   output logic [ADDR_W-1:0]       rom_addr,
   input  logic [DATA_W-1:0]       rom_q
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_REQ - 1);
   localparam logic [IDX_W-1:0] FIRST_SPR  = IDX_W'(1);
   localparam logic [N_REQ-1:0] ONE_HOT0   = {{(N_REQ-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]   starve_cnt_q [1:N_REQ-1];
   logic [CNT_W-1:0]   starve_cnt_d [1:N_REQ-1];
   logic [ROM_LAT-1:0] tag_vld_q;
   logic [IDX_W-1:0]   tag_idx_q [ROM_LAT];
   logic [ADDR_W-1:0]  rom_addr_q;
   logic [N_REQ-1:0]   rd_valid_q;
   logic [DATA_W-1:0]  rd_data_q;
   logic               bg_miss_q;

   logic               starve_hit_s;
   logic               gnt_any_s;
   logic [IDX_W-1:0]   gnt_idx_s;
   logic [IDX_W:0]     rr_sum_s;
   logic [IDX_W-1:0]   rr_cand_s;
   logic [N_REQ-1:0]   gnt_s;
   logic [ADDR_W-1:0]  gnt_addr_s;

   // Grant selection: starve override (lowest index), then background, then round-robin sprites.
   always_comb begin
      logic starve_now;
      logic take;
      starve_hit_s = 1'b0;
      gnt_any_s    = 1'b0;
      gnt_idx_s    = '0;
      rr_sum_s     = '0;
      rr_cand_s    = '0;
      starve_now   = 1'b0;
      take         = 1'b0;
      // Descending scan so the lowest starving index is the last one written.
      for (int i = N_REQ - 1; i >= 1; i--) begin
         starve_now   = req[i] && (starve_cnt_q[i] >= STARVE_LIM);
         starve_hit_s = starve_hit_s | starve_now;
         gnt_idx_s    = starve_now ? IDX_W'(i) : gnt_idx_s;
      end
      if (starve_hit_s) begin
         gnt_any_s = 1'b1;
      end else if (req[0]) begin
         gnt_any_s = 1'b1;
         gnt_idx_s = '0;
      end else begin
         // Search sprites from rr_ptr upward, wrapping N_REQ-1 back to 1.
         for (int k = 0; k < N_REQ - 1; k++) begin
            rr_sum_s  = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
            rr_cand_s = (rr_sum_s > {1'b0, LAST_IDX}) ?
                        IDX_W'(rr_sum_s - (IDX_W+1)'(N_REQ - 1)) : rr_sum_s[IDX_W-1:0];
            take      = !gnt_any_s && req[rr_cand_s];
            gnt_any_s = gnt_any_s | take;
            gnt_idx_s = take ? rr_cand_s : gnt_idx_s;
         end
      end
   end

   // Decode the winner into a one-hot grant and pick its address.
   always_comb begin
      logic sel;
      gnt_s      = '0;
      gnt_addr_s = '0;
      sel        = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         sel        = gnt_any_s && (gnt_idx_s == IDX_W'(i));
         gnt_s[i]   = sel;
         gnt_addr_s = sel ? req_addr[i*ADDR_W +: ADDR_W] : gnt_addr_s;
      end
   end

   // The grant is forced low while reset is held, even though it is combinational.
   assign gnt = reset ? '0 : gnt_s;

   // Next round-robin pointer and saturating starve counters.
   always_comb begin
      if (gnt_any_s && (gnt_idx_s != '0)) begin
         rr_ptr_d = (gnt_idx_s == LAST_IDX) ? FIRST_SPR : gnt_idx_s + FIRST_SPR;
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
      for (int i = 1; i < N_REQ; i++) begin
         if (!req[i] || gnt_s[i]) begin
            starve_cnt_d[i] = '0;
         end else if (starve_cnt_q[i] < STARVE_LIM) begin
            starve_cnt_d[i] = starve_cnt_q[i] + CNT_W'(1);
         end else begin
            starve_cnt_d[i] = starve_cnt_q[i];
         end
      end
   end

   // Arbitration state, ROM address, tag pipeline and registered read return.
   always_ff @(posedge vga_clk or posedge reset) begin
      if (reset) begin
         rr_ptr_q <= FIRST_SPR;
         for (int i = 1; i < N_REQ; i++) begin
            starve_cnt_q[i] <= '0;
         end
         tag_vld_q <= '0;
         for (int k = 0; k < ROM_LAT; k++) begin
            tag_idx_q[k] <= '0;
         end
         rom_addr_q <= '0;
         rd_valid_q <= '0;
         rd_data_q  <= '0;
         bg_miss_q  <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         for (int i = 1; i < N_REQ; i++) begin
            starve_cnt_q[i] <= starve_cnt_d[i];
         end
         rom_addr_q   <= gnt_any_s ? gnt_addr_s : rom_addr_q;
         tag_vld_q[0] <= gnt_any_s;
         tag_idx_q[0] <= gnt_idx_s;
         for (int k = 1; k < ROM_LAT; k++) begin
            tag_vld_q[k] <= tag_vld_q[k-1];
            tag_idx_q[k] <= tag_idx_q[k-1];
         end
         // The oldest tag lines up with the edge at which rom_q holds its data.
         if (tag_vld_q[ROM_LAT-1]) begin
            rd_valid_q <= ONE_HOT0 << tag_idx_q[ROM_LAT-1];
            rd_data_q  <= rom_q;
         end else begin
            rd_valid_q <= '0;
         end
         bg_miss_q <= req[0] && !gnt_s[0];
      end
   end

   assign rd_valid = rd_valid_q;
   assign rd_data  = rd_data_q;
   assign bg_miss  = bg_miss_q;
   assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Testbench for rom_port_arbiter: a rule-level reference model (grant rules,
// pointer, starve counts, queue of pending reads with due cycles) is run
// beside the DUT. A second instance built with ROM_LAT=3 checks the longer
// return latency.
module tb_rom_port_arbiter;

   localparam int N_REQ      = 3;
   localparam int ADDR_W     = 18;
   localparam int DATA_W     = 5;
   localparam int ROM_LAT    = 1;
   localparam int STARVE_MAX = 8;

   logic                    vga_clk  = 1'b0;
   logic                    reset    = 1'b1;
   logic [N_REQ-1:0]        req      = '0;
   logic [N_REQ*ADDR_W-1:0] req_addr = '0;
   logic [N_REQ-1:0]        gnt, rd_valid;
   logic [DATA_W-1:0]       rd_data, rom_q;
   logic                    bg_miss;
   logic [ADDR_W-1:0]       rom_addr;

   logic [N_REQ-1:0]        req3      = '0;
   logic [N_REQ*ADDR_W-1:0] req_addr3 = '0;
   logic [N_REQ-1:0]        gnt3, rd_valid3;
   logic [DATA_W-1:0]       rd_data3, rom_q3, rom3_d1, rom3_d2;
   logic                    bg_miss3;
   logic [ADDR_W-1:0]       rom_addr3;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 vga_clk = ~vga_clk;

   // ROM content model: each word is the low DATA_W bits of its address.
   assign rom_q = rom_addr[DATA_W-1:0];

   // Three-cycle ROM: two extra registers behind the address register.
   always @(posedge vga_clk) begin
      rom3_d1 <= rom_addr3[DATA_W-1:0];
      rom3_d2 <= rom3_d1;
   end
   assign rom_q3 = rom3_d2;

   rom_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .ROM_LAT(ROM_LAT), .STARVE_MAX(STARVE_MAX)) u_dut (
      .vga_clk(vga_clk), .reset(reset), .req(req), .req_addr(req_addr),
      .gnt(gnt), .rd_valid(rd_valid), .rd_data(rd_data), .bg_miss(bg_miss),
      .rom_addr(rom_addr), .rom_q(rom_q));

   rom_port_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                      .ROM_LAT(3), .STARVE_MAX(STARVE_MAX)) u_dut3 (
      .vga_clk(vga_clk), .reset(reset), .req(req3), .req_addr(req_addr3),
      .gnt(gnt3), .rd_valid(rd_valid3), .rd_data(rd_data3), .bg_miss(bg_miss3),
      .rom_addr(rom_addr3), .rom_q(rom_q3));

   // ---------------- reference model ----------------
   typedef struct { int due; int idx; logic [DATA_W-1:0] data; } rd_t;
   rd_t               m_q[$];
   int                m_starve[N_REQ];
   int                m_rr, m_cyc, m_g;
   logic              m_bgm;
   logic [DATA_W-1:0] m_rdd;
   logic [ADDR_W-1:0] m_rom_addr;
   logic [N_REQ-1:0]  exp_gnt, exp_rdv;
   logic [DATA_W-1:0] exp_rdd;
   logic              exp_bgm;
   logic [ADDR_W-1:0] exp_rom_addr;

   function automatic logic [N_REQ-1:0] onehot(input int i);
      return N_REQ'(1 << i);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N_REQ; i++) m_starve[i] = 0;
      m_rr = 1; m_cyc = 0; m_g = -1;
      m_q.delete();
      m_bgm = 1'b0; m_rdd = '0; m_rom_addr = '0;
   endtask

   // Expected outputs for the current cycle from the current req and model state.
   task automatic model_eval();
      int c;
      m_g = -1;
      for (int i = 1; i < N_REQ; i++)
         if (m_g < 0 && req[i] && m_starve[i] >= STARVE_MAX) m_g = i;
      if (m_g < 0 && req[0]) m_g = 0;
      for (int k = 0; k < N_REQ - 1; k++) begin
         c = (m_rr - 1 + k) % (N_REQ - 1) + 1;
         if (m_g < 0 && req[c]) m_g = c;
      end
      exp_gnt = (m_g < 0) ? '0 : onehot(m_g);
      exp_rdv = '0;
      if (m_q.size() > 0 && m_q[0].due == m_cyc) begin
         exp_rdv = onehot(m_q[0].idx);
         m_rdd   = m_q[0].data;
         void'(m_q.pop_front());
      end
      exp_rdd      = m_rdd;
      exp_bgm      = m_bgm;
      exp_rom_addr = m_rom_addr;
   endtask

   // State change across the clock edge that ends the current cycle.
   task automatic model_commit();
      rd_t e;
      m_bgm = req[0] && (m_g != 0);
      for (int i = 1; i < N_REQ; i++) begin
         if (!req[i] || m_g == i) m_starve[i] = 0;
         else if (m_starve[i] < STARVE_MAX) m_starve[i]++;
      end
      if (m_g >= 0) begin
         m_rom_addr = req_addr[m_g*ADDR_W +: ADDR_W];
         e.due  = m_cyc + 1 + ROM_LAT;
         e.idx  = m_g;
         e.data = m_rom_addr[DATA_W-1:0];
         m_q.push_back(e);
         if (m_g >= 1) m_rr = (m_g == N_REQ - 1) ? 1 : m_g + 1;
      end
      m_cyc++;
   endtask

   task automatic new_addr(input int i);
      req_addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1'b1; req = '1;
      for (int i = 0; i < N_REQ; i++) new_addr(i);
      repeat (2) @(posedge vga_clk);
      @(negedge vga_clk);
      tests_run++; if (gnt !== 3'b000) begin tests_failed++; $display("FAIL reset_gnt got=%b exp=000", gnt); end
      tests_run++; if (rd_valid !== 3'b000) begin tests_failed++; $display("FAIL reset_rd_valid got=%b exp=000", rd_valid); end
      tests_run++; if (rom_addr !== 18'h0) begin tests_failed++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
      tests_run++; if (rd_data !== 5'h0 || bg_miss !== 1'b0) begin tests_failed++; $display("FAIL reset_data_miss got=%h/%b exp=0/0", rd_data, bg_miss); end
      tests_run++; if (gnt3 !== 3'b000 || rd_valid3 !== 3'b000) begin tests_failed++; $display("FAIL reset_dut3 got=%b/%b exp=000/000", gnt3, rd_valid3); end
      @(posedge vga_clk); #1;
      reset = 1'b0; req = 3'b001; req_addr[0 +: ADDR_W] = 18'h00123;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt || gnt !== ((c == 0) ? 3'b001 : 3'b000)) begin tests_failed++; $display("FAIL first_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
         tests_run++; if (rd_valid !== exp_rdv || rd_valid !== ((c == 2) ? 3'b001 : 3'b000)) begin tests_failed++; $display("FAIL first_rd_valid c=%0d got=%b exp=%b", c, rd_valid, exp_rdv); end
         if (c == 2) begin
            tests_run++; if (rd_data !== 5'h03) begin tests_failed++; $display("FAIL first_rd_data got=%h exp=03", rd_data); end
         end
         model_commit(); @(posedge vga_clk); #1;
         req = 3'b000;
      end
   endtask

   task automatic test_priority();
      req = 3'b111;
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt || gnt !== 3'b001) begin tests_failed++; $display("FAIL prio_gnt c=%0d got=%b exp=001", c, gnt); end
         tests_run++; if (bg_miss !== 1'b0) begin tests_failed++; $display("FAIL prio_bg_miss c=%0d got=%b exp=0", c, bg_miss); end
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd || rom_addr !== exp_rom_addr) begin tests_failed++; $display("FAIL prio_return c=%0d got=%b/%h/%h exp=%b/%h/%h", c, rd_valid, rd_data, rom_addr, exp_rdv, exp_rdd, exp_rom_addr); end
         model_commit(); @(posedge vga_clk); #1;
         new_addr(0);
      end
   endtask

   task automatic test_round_robin();
      req = 3'b110;
      for (int c = 0; c < 8; c++) begin
         @(negedge vga_clk); model_eval();
         if (c < 6) begin
            tests_run++; if (gnt !== exp_gnt || gnt !== ((c % 2 == 0) ? 3'b010 : 3'b100)) begin tests_failed++; $display("FAIL rr_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
         end
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd) begin tests_failed++; $display("FAIL rr_return c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, exp_rdv, exp_rdd); end
         model_commit(); @(posedge vga_clk); #1;
         if (m_g > 0) new_addr(m_g);
         if (c == 5) req = 3'b000;
      end
   endtask

   task automatic test_starvation();
      req = 3'b011;
      for (int c = 0; c < 12; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt || gnt !== ((c == 8) ? 3'b010 : 3'b001)) begin tests_failed++; $display("FAIL starve_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
         tests_run++; if (bg_miss !== exp_bgm || bg_miss !== (c == 9)) begin tests_failed++; $display("FAIL starve_bg_miss c=%0d got=%b exp=%b", c, bg_miss, exp_bgm); end
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd) begin tests_failed++; $display("FAIL starve_return c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, exp_rdv, exp_rdd); end
         model_commit(); @(posedge vga_clk); #1;
         if (m_g >= 0) new_addr(m_g);
      end
   endtask

   task automatic test_back_to_back();
      req = 3'b111;
      for (int c = 0; c < 24; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL b2b_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd || bg_miss !== exp_bgm || rom_addr !== exp_rom_addr) begin tests_failed++; $display("FAIL b2b_outputs c=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", c, rd_valid, rd_data, bg_miss, rom_addr, exp_rdv, exp_rdd, exp_bgm, exp_rom_addr); end
         if (c >= 2) begin
            tests_run++; if (rd_valid === 3'b000) begin tests_failed++; $display("FAIL b2b_throughput c=%0d got=%b exp=nonzero", c, rd_valid); end
         end
         model_commit(); @(posedge vga_clk); #1;
         new_addr(m_g);
      end
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt) begin tests_failed++; $display("FAIL rand_gnt c=%0d got=%b exp=%b", c, gnt, exp_gnt); end
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd || bg_miss !== exp_bgm || rom_addr !== exp_rom_addr) begin tests_failed++; $display("FAIL rand_outputs c=%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", c, rd_valid, rd_data, bg_miss, rom_addr, exp_rdv, exp_rdd, exp_bgm, exp_rom_addr); end
         model_commit(); @(posedge vga_clk); #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && m_g == i) begin
               req[i] = 1'($urandom_range(0, 1)); new_addr(i);
            end else if (req[i]) begin
               if ($urandom_range(0, 7) == 0) req[i] = 1'b0;
            end else begin
               req[i] = (i == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1));
               new_addr(i);
            end
         end
      end
   endtask

   task automatic test_reset_midflight();
      req = 3'b000;
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (rd_valid !== exp_rdv || rd_data !== exp_rdd) begin tests_failed++; $display("FAIL mid_drain c=%0d got=%b/%h exp=%b/%h", c, rd_valid, rd_data, exp_rdv, exp_rdd); end
         model_commit(); @(posedge vga_clk); #1;
      end
      req = 3'b111; req3 = 3'b100; req_addr3[2*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      for (int c = 0; c < 3; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt !== exp_gnt || rd_valid !== exp_rdv) begin tests_failed++; $display("FAIL mid_issue c=%0d got=%b/%b exp=%b/%b", c, gnt, rd_valid, exp_gnt, exp_rdv); end
         tests_run++; if (gnt3 !== 3'b100) begin tests_failed++; $display("FAIL mid_issue3 c=%0d got=%b exp=100", c, gnt3); end
         model_commit(); @(posedge vga_clk); #1;
         new_addr(m_g); req_addr3[2*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      end
      #1; reset = 1'b1; #1;
      tests_run++; if (gnt !== 3'b000 || rd_valid !== 3'b000 || bg_miss !== 1'b0) begin tests_failed++; $display("FAIL mid_reset_ctl got=%b/%b/%b exp=000/000/0", gnt, rd_valid, bg_miss); end
      tests_run++; if (rom_addr !== 18'h0 || rd_data !== 5'h0) begin tests_failed++; $display("FAIL mid_reset_data got=%h/%h exp=0/0", rom_addr, rd_data); end
      tests_run++; if (gnt3 !== 3'b000 || rd_valid3 !== 3'b000 || rom_addr3 !== 18'h0) begin tests_failed++; $display("FAIL mid_reset_dut3 got=%b/%b/%h exp=000/000/0", gnt3, rd_valid3, rom_addr3); end
      model_reset();
      repeat (2) @(posedge vga_clk); #1;
      reset = 1'b0; req = 3'b000; req3 = 3'b000;
      for (int c = 0; c < 8; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (rd_valid !== 3'b000 || rd_valid !== exp_rdv) begin tests_failed++; $display("FAIL mid_no_return c=%0d got=%b exp=000", c, rd_valid); end
         tests_run++; if (rd_valid3 !== 3'b000) begin tests_failed++; $display("FAIL mid_no_return3 c=%0d got=%b exp=000", c, rd_valid3); end
         model_commit(); @(posedge vga_clk); #1;
      end
   endtask

   task automatic test_lat3();
      logic [ADDR_W-1:0] a;
      a = ADDR_W'($urandom);
      req3 = 3'b100; req_addr3[2*ADDR_W +: ADDR_W] = a;
      for (int c = 0; c < 7; c++) begin
         @(negedge vga_clk); model_eval();
         tests_run++; if (gnt3 !== ((c == 0) ? 3'b100 : 3'b000)) begin tests_failed++; $display("FAIL lat3_gnt c=%0d got=%b exp=%b", c, gnt3, (c == 0) ? 3'b100 : 3'b000); end
         tests_run++; if (rd_valid3 !== ((c == 4) ? 3'b100 : 3'b000)) begin tests_failed++; $display("FAIL lat3_rd_valid c=%0d got=%b exp=%b", c, rd_valid3, (c == 4) ? 3'b100 : 3'b000); end
         if (c == 4) begin
            tests_run++; if (rd_data3 !== a[DATA_W-1:0]) begin tests_failed++; $display("FAIL lat3_rd_data got=%h exp=%h", rd_data3, a[DATA_W-1:0]); end
         end
         tests_run++; if (rd_valid !== exp_rdv) begin tests_failed++; $display("FAIL lat3_main_idle c=%0d got=%b exp=%b", c, rd_valid, exp_rdv); end
         model_commit(); @(posedge vga_clk); #1;
         req3 = 3'b000;
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_priority();
      test_round_robin();
      test_starvation();
      test_back_to_back();
      test_random();
      test_reset_midflight();
      test_lat3();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
